// File: rtl/traffic_density_estimator.sv
// Per-direction detector synchronizer, debouncer and windowed vehicle counter
// producing registered 2-bit density levels for the light controller.
module traffic_density_estimator #(
  parameter int WINDOW_CYCLES = 200,
  parameter int DEBOUNCE      = 3,
  parameter int CNT_W         = 8,
  parameter int THR1          = 2,
  parameter int THR2          = 5,
  parameter int THR3          = 9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       det_N,
  input  logic       det_E,
  output logic [1:0] sensor_N,
  output logic [1:0] sensor_E,
  output logic       window_tick
);

  localparam int WCNT_W = $clog2(WINDOW_CYCLES);
  localparam int STAB_W = $clog2(DEBOUNCE + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WCNT_W-1:0] wcnt;
  logic              terminal;
  logic [1:0]        det;
  logic [1:0]        level_q [2];

  assign det      = {det_E, det_N};
  assign terminal = (wcnt == WCNT_W'(WINDOW_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wcnt        <= '0;
      window_tick <= 1'b0;
    end else begin
      wcnt        <= terminal ? '0 : wcnt + WCNT_W'(1);
      window_tick <= terminal;
    end
  end

  // Index 0 is the north path, index 1 the east path; the two never interact.
  for (genvar d = 0; d < 2; d++) begin : gen_dir
    logic [1:0]        sync_q;
    logic              s;
    logic              deb;
    logic [STAB_W-1:0] stab;
    logic              arr;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  next_cnt;
    logic [31:0]       cnt_ext;
    logic [1:0]        level;
    logic [1:0]        lvl_q;

    assign s = sync_q[1];

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        sync_q <= '0;
        deb    <= 1'b0;
        stab   <= '0;
        arr    <= 1'b0;
      end else begin
        sync_q <= {sync_q[0], det[d]};
        if (s == deb) begin
          stab <= '0;
          arr  <= 1'b0;
        end else if (stab == STAB_W'(DEBOUNCE - 1)) begin
          // Accepting a new level; only a 0->1 acceptance is a vehicle arrival.
          deb  <= s;
          stab <= '0;
          arr  <= s;
        end else begin
          stab <= stab + STAB_W'(1);
          arr  <= 1'b0;
        end
      end
    end

    // Arrival on the terminal cycle still belongs to the closing window.
    always_comb begin
      next_cnt = cnt;
      if (arr && (cnt != CNT_MAX)) next_cnt = cnt + CNT_W'(1);
    end

    assign cnt_ext = 32'(next_cnt);

    always_comb begin
      level = 2'd3;
      if (cnt_ext < 32'(THR1))      level = 2'd0;
      else if (cnt_ext < 32'(THR2)) level = 2'd1;
      else if (cnt_ext < 32'(THR3)) level = 2'd2;
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        cnt   <= '0;
        lvl_q <= 2'd0;
      end else if (terminal) begin
        cnt   <= '0;
        lvl_q <= level;
      end else begin
        cnt   <= next_cnt;
      end
    end

    assign level_q[d] = lvl_q;
  end

  assign sensor_N = level_q[0];
  assign sensor_E = level_q[1];

endmodule

// File: tb/tb_traffic_density_estimator.sv
// Bench for traffic_density_estimator: default instance plus a narrow-counter
// instance (CNT_W=3, THR3=7) sharing the same detector stimulus.
module tb_traffic_density_estimator;

  logic       clk = 1'b0;
  logic       reset;
  logic       det_n, det_e;
  logic [1:0] sensor_n, sensor_e, sat_n, sat_e;
  logic       tick, sat_tick;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_tick = 0;
  logic [1:0] cur_n = 0, cur_e = 0, cur_sn = 0, cur_se = 0;

  typedef struct {
    int n_cnt; int n_hi; int e_cnt; int e_hi; int lo;
    int exp_n; int exp_e; int exp_sn; int exp_se;
  } vec_t;
  vec_t vecs[8];

  traffic_density_estimator dut (
    .clk(clk), .reset(reset), .det_N(det_n), .det_E(det_e),
    .sensor_N(sensor_n), .sensor_E(sensor_e), .window_tick(tick)
  );

  traffic_density_estimator #(.CNT_W(3), .THR3(7)) dut_sat (
    .clk(clk), .reset(reset), .det_N(det_n), .det_E(det_e),
    .sensor_N(sat_n), .sensor_E(sat_e), .window_tick(sat_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: saturate the vehicle count, then bin against thresholds 2/5/t3.
  function automatic int quant(input int c, input int cw, input int t3);
    int m;
    m = (c > (1 << cw) - 1) ? (1 << cw) - 1 : c;
    if (m < 2) return 0;
    if (m < 5) return 1;
    if (m < t3) return 2;
    return 3;
  endfunction

  // Cycle monitor: zero outputs in reset, 200-cycle tick period, levels held.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (!reset) begin
      last_tick = cyc;
      check("reset_sensor_n", sensor_n, 0);
      check("reset_sensor_e", sensor_e, 0);
      check("reset_tick", tick, 0);
      check("reset_sat_n", sat_n, 0);
      check("reset_sat_e", sat_e, 0);
    end else if (tick) begin
      check("tick_period", cyc - last_tick, 200);
      last_tick = cyc;
    end else begin
      check("hold_n", sensor_n, cur_n);
      check("hold_e", sensor_e, cur_e);
      check("hold_sat_n", sat_n, cur_sn);
      check("hold_sat_e", sat_e, cur_se);
    end
  end

  task automatic drive_pulse(input bit dir, input int hi, input int lo);
    if (dir) det_e = 1'b1; else det_n = 1'b1;
    repeat (hi) @(negedge clk);
    if (dir) det_e = 1'b0; else det_n = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic wait_tick(output int cycles, output bit ok);
    cycles = 0;
    ok = 1'b0;
    while (cycles < 400 && !ok) begin
      @(negedge clk);
      cycles++;
      if (tick) ok = 1'b1;
    end
  endtask

  task automatic check_window(input string name, input int en, input int ee,
                              input int esn, input int ese);
    int c;
    bit ok;
    wait_tick(c, ok);
    check({name, ".tick_seen"}, int'(ok), 1);
    check({name, ".sat_tick"}, int'(sat_tick), 1);
    check({name, ".sensor_n"}, sensor_n, en);
    check({name, ".sensor_e"}, sensor_e, ee);
    check({name, ".sat_n"}, sat_n, esn);
    check({name, ".sat_e"}, sat_e, ese);
    cur_n = 2'(en); cur_e = 2'(ee); cur_sn = 2'(esn); cur_se = 2'(ese);
  endtask

  initial begin
    int c;
    bit ok;
    int hi_n[$], lo_n[$], hi_e[$], lo_e[$];
    int vn, ve, ev, hi;
    bit valid;

    vecs[0] = '{3, 6, 10, 6, 6, 1, 3, 1, 3};
    vecs[1] = '{0, 3, 1, 3, 3, 0, 0, 0, 0};
    vecs[2] = '{2, 3, 5, 3, 3, 1, 2, 1, 2};
    vecs[3] = '{20, 2, 3, 3, 3, 0, 1, 0, 1};
    vecs[4] = '{12, 3, 6, 4, 3, 3, 2, 3, 2};
    vecs[5] = '{9, 5, 4, 5, 4, 3, 1, 3, 1};
    vecs[6] = '{5, 7, 8, 3, 3, 2, 2, 2, 3};
    vecs[7] = '{1, 4, 7, 4, 4, 0, 2, 0, 3};

    // Reset held with detectors toggling.
    reset = 1'b0; det_n = 1'b0; det_e = 1'b0;
    repeat (20) begin
      @(negedge clk);
      det_n = 1'($urandom_range(0, 1));
      det_e = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    check("reset.sensor_n", sensor_n, 0);
    check("reset.sensor_e", sensor_e, 0);
    check("reset.tick", tick, 0);
    det_n = 1'b0; det_e = 1'b0;
    reset = 1'b1;
    wait_tick(c, ok);
    check("first_tick.seen", int'(ok), 1);
    check("first_tick.delay", c, 200);
    check("first_tick.sensor_n", sensor_n, 0);
    check("first_tick.sensor_e", sensor_e, 0);

    // Directed table: one window per entry, starting right after a tick.
    for (int i = 0; i < 8; i++) begin
      fork
        begin
          for (int k = 0; k < vecs[i].n_cnt; k++) drive_pulse(0, vecs[i].n_hi, vecs[i].lo);
        end
        begin
          for (int k = 0; k < vecs[i].e_cnt; k++) drive_pulse(1, vecs[i].e_hi, vecs[i].lo);
        end
      join
      check_window($sformatf("vec%0d", i), vecs[i].exp_n, vecs[i].exp_e,
                   vecs[i].exp_sn, vecs[i].exp_se);
    end

    // Random mixes of clean pulses (>=3 cycles) and glitches (<=2 cycles).
    for (int w = 0; w < 8; w++) begin
      hi_n.delete(); lo_n.delete(); hi_e.delete(); lo_e.delete();
      vn = 0; ve = 0;
      ev = $urandom_range(0, 14);
      for (int k = 0; k < ev; k++) begin
        valid = ($urandom_range(0, 3) != 0);
        hi = valid ? $urandom_range(3, 6) : $urandom_range(1, 2);
        hi_n.push_back(hi); lo_n.push_back($urandom_range(3, 6));
        if (valid) vn++;
      end
      ev = $urandom_range(0, 14);
      for (int k = 0; k < ev; k++) begin
        valid = ($urandom_range(0, 3) != 0);
        hi = valid ? $urandom_range(3, 6) : $urandom_range(1, 2);
        hi_e.push_back(hi); lo_e.push_back($urandom_range(3, 6));
        if (valid) ve++;
      end
      fork
        begin
          foreach (hi_n[k]) drive_pulse(0, hi_n[k], lo_n[k]);
        end
        begin
          foreach (hi_e[k]) drive_pulse(1, hi_e[k], lo_e[k]);
        end
      join
      check_window($sformatf("rand%0d", w), quant(vn, 8, 9), quant(ve, 8, 9),
                   quant(vn, 3, 7), quant(ve, 3, 7));
    end

    // Window edge: arrivals in cycle 5 and in the terminal cycle 199.
    drive_pulse(0, 4, 190);
    drive_pulse(0, 4, 0);
    check_window("edge", 1, 0, 1, 0);
    repeat (5) drive_pulse(1, 3, 3);
    check_window("after_edge", 0, 2, 0, 2);

    // Mid-window reset at wcnt=100 with six east arrivals already counted.
    repeat (6) drive_pulse(1, 3, 3);
    repeat (64) @(negedge clk);
    reset = 1'b0;
    cur_n = 0; cur_e = 0; cur_sn = 0; cur_se = 0;
    #1;
    check("mid_reset.sensor_n", sensor_n, 0);
    check("mid_reset.sensor_e", sensor_e, 0);
    check("mid_reset.tick", tick, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    fork
      begin
        repeat (2) drive_pulse(0, 3, 3);
      end
      drive_pulse(1, 3, 3);
    join
    check_window("post_reset", 1, 0, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    n_bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
